// File: rtl/apu_pkg.sv
// Shared types and defaults for the phase slot scheduler.
//   sched_state_t    : scheduler FSM state (IDLE, SWEEP)
//   DEF_NUM_CHANNELS : default number of voice channels sharing one adder
//   DEF_PHASE_WIDTH  : default phase accumulator / delta width
//   ch_idx_t         : channel index type for the default channel count
package apu_pkg;

    localparam int DEF_NUM_CHANNELS = 4;
    localparam int DEF_PHASE_WIDTH  = 32;
    localparam int DEF_CH_BITS      = $clog2(DEF_NUM_CHANNELS);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sched_state_t;

    typedef logic [DEF_CH_BITS-1:0] ch_idx_t;

endpackage

// File: rtl/phase_slot_regfile.sv
// Per-channel delta storage for the phase slot scheduler.
// Writes land in a shadow bank; a commit copies shadow to the active bank
// (a write in the commit cycle bypasses straight into the active bank) and
// turns the pending phase-clear flags into the sweep mask.
// Ports:
//   i_clk, i_reset    clock, async active-high reset
//   i_wr_en           accepted delta write this cycle
//   i_wr_channel      target channel (values >= NUM_CHANNELS are dropped)
//   i_wr_delta        new delta
//   i_wr_phase_clr    request phase clear of the channel at the next sweep
//   i_commit          sweep start: shadow -> active, clr flags -> mask
//   o_active_delta    deltas used by the sweep in progress
//   o_sweep_mask      channels whose phase restarts from 0 in this sweep
module phase_slot_regfile
    import apu_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int PHASE_WIDTH  = DEF_PHASE_WIDTH,
    parameter int CH_BITS      = $clog2(NUM_CHANNELS)
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic                                    i_wr_en,
    input  logic [CH_BITS-1:0]                      i_wr_channel,
    input  logic [PHASE_WIDTH-1:0]                  i_wr_delta,
    input  logic                                    i_wr_phase_clr,
    input  logic                                    i_commit,
    output logic [NUM_CHANNELS-1:0][PHASE_WIDTH-1:0] o_active_delta,
    output logic [NUM_CHANNELS-1:0]                 o_sweep_mask
);

    logic [NUM_CHANNELS-1:0][PHASE_WIDTH-1:0] shadow_q;
    logic [NUM_CHANNELS-1:0][PHASE_WIDTH-1:0] active_q;
    logic [NUM_CHANNELS-1:0]                  clr_q;
    logic [NUM_CHANNELS-1:0]                  mask_q;
    logic [NUM_CHANNELS-1:0]                  wr_hit_d;

    // One-hot write decode; an out-of-range channel matches nothing.
    always_comb begin
        wr_hit_d = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            wr_hit_d[i] = i_wr_en && (i_wr_channel == CH_BITS'(i));
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shadow_q <= '0;
            active_q <= '0;
            clr_q    <= '0;
            mask_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (wr_hit_d[i]) begin
                    shadow_q[i] <= i_wr_delta;
                end
                if (i_commit) begin
                    active_q[i] <= wr_hit_d[i] ? i_wr_delta : shadow_q[i];
                    mask_q[i]   <= clr_q[i] | (wr_hit_d[i] & i_wr_phase_clr);
                    clr_q[i]    <= 1'b0;
                end else if (wr_hit_d[i] && i_wr_phase_clr) begin
                    clr_q[i] <= 1'b1;
                end
            end
        end
    end

    assign o_active_delta = active_q;
    assign o_sweep_mask   = mask_q;

endmodule

// File: rtl/phase_slot_scheduler.sv
// Time-multiplexes one phase adder across NUM_CHANNELS voice channels.
// Each accepted sample strobe starts a sweep that advances every channel's
// phase once, channel 0 first, one channel per clock.
// Optional feature macro: PHASE_SLOT_HARD_SYNC_EN -- when defined, a wrap of
// channel 0 within a sweep restarts channel 1 from 0 (oscillator hard sync).
// Ports:
//   i_clk, i_reset     clock, async active-high reset
//   i_sample_stb       start one sweep (ignored while busy -> o_overrun)
//   i_wr_valid/o_wr_ready, i_wr_channel, i_wr_delta, i_wr_phase_clr
//                      delta write port (always ready after reset)
//   o_phase_valid      o_phase / o_phase_channel valid this cycle
//   o_phase_channel    channel of o_phase
//   o_phase            updated phase
//   o_busy             sweep in progress
//   o_overrun          1-cycle pulse: strobe dropped while busy
module phase_slot_scheduler
    import apu_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int PHASE_WIDTH  = DEF_PHASE_WIDTH,
    parameter int CH_BITS      = $clog2(NUM_CHANNELS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_sample_stb,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    input  logic [CH_BITS-1:0]     i_wr_channel,
    input  logic [PHASE_WIDTH-1:0] i_wr_delta,
    input  logic                   i_wr_phase_clr,
    output logic                   o_phase_valid,
    output logic [CH_BITS-1:0]     o_phase_channel,
    output logic [PHASE_WIDTH-1:0] o_phase,
    output logic                   o_busy,
    output logic                   o_overrun
);

    sched_state_t                             state_q;
    logic [CH_BITS-1:0]                       slot_q;
    logic [NUM_CHANNELS-1:0][PHASE_WIDTH-1:0] phase_q;
    logic                                     ready_q;
    logic                                     busy_q;
    logic                                     overrun_q;
    logic                                     valid_q;
    logic [CH_BITS-1:0]                       out_ch_q;
    logic [PHASE_WIDTH-1:0]                   out_phase_q;

    logic                                     wr_en_d;
    logic                                     commit_d;
    logic                                     clr_base_d;
    logic [PHASE_WIDTH-1:0]                   base_d;
    logic [PHASE_WIDTH-1:0]                   sum_d;
    logic [NUM_CHANNELS-1:0][PHASE_WIDTH-1:0] active_delta;
    logic [NUM_CHANNELS-1:0]                  sweep_mask;
`ifdef PHASE_SLOT_HARD_SYNC_EN
    logic                                     sync_q;
    logic                                     carry_d;
`endif

    assign wr_en_d  = i_wr_valid & ready_q;
    assign commit_d = (state_q == IDLE) & i_sample_stb;

    phase_slot_regfile #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .PHASE_WIDTH  (PHASE_WIDTH),
        .CH_BITS      (CH_BITS)
    ) u_regfile (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_wr_en        (wr_en_d),
        .i_wr_channel   (i_wr_channel),
        .i_wr_delta     (i_wr_delta),
        .i_wr_phase_clr (i_wr_phase_clr),
        .i_commit       (commit_d),
        .o_active_delta (active_delta),
        .o_sweep_mask   (sweep_mask)
    );

    // Shared adder for the current slot; a masked channel restarts from 0.
    always_comb begin
        clr_base_d = sweep_mask[slot_q];
`ifdef PHASE_SLOT_HARD_SYNC_EN
        clr_base_d = clr_base_d | (sync_q && (slot_q == CH_BITS'(1)));
`endif
        base_d = clr_base_d ? '0 : phase_q[slot_q];
`ifdef PHASE_SLOT_HARD_SYNC_EN
        {carry_d, sum_d} = {1'b0, base_d} + {1'b0, active_delta[slot_q]};
`else
        sum_d = base_d + active_delta[slot_q];
`endif
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            phase_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            valid_q     <= 1'b0;
            out_ch_q    <= '0;
            out_phase_q <= '0;
`ifdef PHASE_SLOT_HARD_SYNC_EN
            sync_q      <= 1'b0;
`endif
        end else begin
            ready_q   <= 1'b1;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_sample_stb) begin
                        state_q <= SWEEP;
                        slot_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    overrun_q <= i_sample_stb;
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        if (slot_q == CH_BITS'(i)) begin
                            phase_q[i] <= sum_d;
                        end
                    end
                    valid_q     <= 1'b1;
                    out_ch_q    <= slot_q;
                    out_phase_q <= sum_d;
`ifdef PHASE_SLOT_HARD_SYNC_EN
                    if (slot_q == '0) begin
                        sync_q <= carry_d;
                    end
`endif
                    if (slot_q == CH_BITS'(NUM_CHANNELS - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        slot_q <= slot_q + CH_BITS'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_wr_ready      = ready_q;
    assign o_busy          = busy_q;
    assign o_overrun       = overrun_q;
    assign o_phase_valid   = valid_q;
    assign o_phase_channel = out_ch_q;
    assign o_phase         = out_phase_q;

endmodule

// File: tb/tb_phase_slot_scheduler.sv
module tb_phase_slot_scheduler;

    localparam int N    = 4;
    localparam int PW   = 32;
    localparam int CB   = 2;
    localparam int MAXC = 4096;
`ifdef PHASE_SLOT_HARD_SYNC_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          stb, wv, clr;
    logic [CB-1:0] wch;
    logic [PW-1:0] wd;
    logic          o_wr_ready, o_phase_valid, o_busy, o_overrun;
    logic [CB-1:0] o_phase_channel;
    logic [PW-1:0] o_phase;

    always #5 clk = ~clk;

    phase_slot_scheduler #(.NUM_CHANNELS(N), .PHASE_WIDTH(PW), .CH_BITS(CB)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_sample_stb    (stb),
        .i_wr_valid      (wv),
        .o_wr_ready      (o_wr_ready),
        .i_wr_channel    (wch),
        .i_wr_delta      (wd),
        .i_wr_phase_clr  (clr),
        .o_phase_valid   (o_phase_valid),
        .o_phase_channel (o_phase_channel),
        .o_phase         (o_phase),
        .o_busy          (o_busy),
        .o_overrun       (o_overrun)
    );

    // Reference model: sweep-level arithmetic, expectations scheduled per cycle.
    logic [PW-1:0] m_shadow[N];
    logic [PW-1:0] m_phase[N];
    bit            m_clr[N];
    int            busy_end;
    bit            e_valid[MAXC];
    bit            e_busy[MAXC];
    bit            e_ovr[MAXC];
    logic [CB-1:0] e_ch[MAXC];
    logic [PW-1:0] e_ph[MAXC];

    int            cyc, total, bad, n_ovr;
    logic [CB-1:0] seen_ch[$];
    logic [PW-1:0] seen_ph[$];

    typedef struct {
        bit            stb;
        bit            wv;
        logic [CB-1:0] ch;
        logic [PW-1:0] d;
        bit            busy;
        bit            valid;
        logic [CB-1:0] ech;
        logic [PW-1:0] eph;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_cycle(input int c, input bit s, input bit w, input logic [CB-1:0] ch,
                               input logic [PW-1:0] d, input bit cl);
        bit            mask[N];
        bit            wrap0;
        logic [PW-1:0] base;
        logic [PW:0]   sum;
        if (c + N + 3 >= MAXC) begin
            $display("FAIL cycle_budget: got=%0d expected below %0d", c, MAXC - N - 3);
            $fatal(1);
        end
        if (w) begin
            m_shadow[ch] = d;
            if (cl) m_clr[ch] = 1'b1;
        end
        if (s) begin
            if (c <= busy_end) begin
                e_ovr[c+1] = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    mask[k]  = m_clr[k];
                    m_clr[k] = 1'b0;
                end
                wrap0 = 1'b0;
                for (int k = 0; k < N; k++) begin
                    base = (mask[k] || (HS && k == 1 && wrap0)) ? '0 : m_phase[k];
                    sum  = {1'b0, base} + {1'b0, m_shadow[k]};
                    if (k == 0) wrap0 = sum[PW];
                    m_phase[k]     = sum[PW-1:0];
                    e_valid[c+2+k] = 1'b1;
                    e_ch[c+2+k]    = CB'(k);
                    e_ph[c+2+k]    = sum[PW-1:0];
                end
                for (int j = 1; j <= N; j++) e_busy[c+j] = 1'b1;
                busy_end = c + N;
            end
        end
    endtask

    task automatic check_cycle(input int c);
        chk("busy", o_busy, e_busy[c]);
        chk("valid", o_phase_valid, e_valid[c]);
        chk("overrun", o_overrun, e_ovr[c]);
        chk("wr_ready", o_wr_ready, 1);
        if (e_valid[c]) begin
            chk("channel", o_phase_channel, e_ch[c]);
            chk("phase", o_phase, e_ph[c]);
        end
        if (o_phase_valid) begin
            seen_ch.push_back(o_phase_channel);
            seen_ph.push_back(o_phase);
        end
        if (o_overrun) n_ovr++;
    endtask

    task automatic step(input bit s, input bit w, input logic [CB-1:0] ch,
                        input logic [PW-1:0] d, input bit cl);
        stb = s; wv = w; wch = ch; wd = d; clr = cl;
        model_cycle(cyc, s, w, ch, d, cl);
        @(posedge clk);
        #1;
        cyc++;
        stb = 1'b0; wv = 1'b0; clr = 1'b0;
        check_cycle(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic clear_seen();
        seen_ch.delete();
        seen_ph.delete();
        n_ovr = 0;
    endtask

    // n-th observed phase of a channel, or a marker value if never seen.
    function automatic logic [PW-1:0] nth_of(input int ch, input int n);
        int cnt = 0;
        for (int i = 0; i < seen_ch.size(); i++) begin
            if (seen_ch[i] == CB'(ch)) begin
                if (cnt == n) return seen_ph[i];
                cnt++;
            end
        end
        return 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset();
        rst = 1'b1; stb = 1'b0; wv = 1'b0; clr = 1'b0; wch = '0; wd = '0;
        #1;
        chk("rst_valid", o_phase_valid, 0);
        chk("rst_channel", o_phase_channel, 0);
        chk("rst_phase", o_phase, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_wr_ready", o_wr_ready, 0);
        repeat (2) @(posedge clk);
        for (int k = 0; k < N; k++) begin
            m_shadow[k] = '0; m_phase[k] = '0; m_clr[k] = 1'b0;
        end
        for (int i = 0; i < MAXC; i++) begin
            e_valid[i] = 1'b0; e_busy[i] = 1'b0; e_ovr[i] = 1'b0; e_ch[i] = '0; e_ph[i] = '0;
        end
        busy_end = -1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        check_cycle(0);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; n_ovr = 0;
        tbl[0] = '{0, 1, 0, 1, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 1, 2, 0, 0, 0, 0};
        tbl[2] = '{0, 1, 2, 3, 0, 0, 0, 0};
        tbl[3] = '{0, 1, 3, 4, 0, 0, 0, 0};
        tbl[4] = '{1, 0, 0, 0, 1, 0, 0, 0};
        tbl[5] = '{0, 0, 0, 0, 1, 1, 0, 1};
        tbl[6] = '{0, 0, 0, 0, 1, 1, 1, 2};
        tbl[7] = '{0, 0, 0, 0, 1, 1, 2, 3};
        tbl[8] = '{0, 0, 0, 0, 0, 1, 3, 4};
        tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 0};

        // Deltas 1..4, one sweep, slot-by-slot timing from a table.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].stb, tbl[i].wv, tbl[i].ch, tbl[i].d, 1'b0);
            chk("tbl_busy", o_busy, tbl[i].busy);
            chk("tbl_valid", o_phase_valid, tbl[i].valid);
            if (tbl[i].valid) begin
                chk("tbl_channel", o_phase_channel, tbl[i].ech);
                chk("tbl_phase", o_phase, tbl[i].eph);
            end
        end

        // Write during a sweep only affects the next sweep.
        clear_seen();
        step(1, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 2, 32'h100, 0);
        idle(5);
        step(1, 0, 0, 0, 0);
        idle(6);
        chk("midsweep_wr_this", nth_of(2, 0), 32'h6);
        chk("midsweep_wr_next", nth_of(2, 1), 32'h106);

        // Strobe while busy -> one overrun pulse, no extra sweep; first IDLE cycle accepted.
        clear_seen();
        step(1, 0, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0);
        idle(2);
        chk("overrun_outputs", seen_ch.size(), 4);
        chk("overrun_pulses", n_ovr, 1);
        step(1, 0, 0, 0, 0);
        idle(6);
        chk("first_idle_strobe_outputs", seen_ch.size(), 8);

        // Channel 0 wrap over five sweeps.
        do_reset();
        clear_seen();
        step(0, 1, 0, 32'h4000_0000, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0);
            idle(7);
        end
        chk("wrap_sweep0", nth_of(0, 0), 32'h4000_0000);
        chk("wrap_sweep1", nth_of(0, 1), 32'h8000_0000);
        chk("wrap_sweep2", nth_of(0, 2), 32'hC000_0000);
        chk("wrap_sweep3", nth_of(0, 3), 32'h0000_0000);
        chk("wrap_sweep4", nth_of(0, 4), 32'h4000_0000);

        // Phase clear and same-cycle write/strobe bypass.
        do_reset();
        clear_seen();
        step(0, 1, 1, 32'h1234, 0);
        step(1, 0, 0, 0, 0);
        idle(6);
        step(0, 1, 1, 32'h5, 1);
        step(1, 0, 0, 0, 0);
        idle(6);
        step(1, 1, 1, 32'h7, 0);
        idle(6);
        chk("clr_before", nth_of(1, 0), 32'h1234);
        chk("clr_restart", nth_of(1, 1), 32'h5);
        chk("bypass_delta", nth_of(1, 2), 32'hC);

        // Reset at slot 2 of a sweep: outputs drop at once, nothing survives.
        step(1, 0, 0, 0, 0);
        idle(2);
        do_reset();
        clear_seen();
        step(1, 0, 0, 0, 0);
        idle(6);
        for (int k = 0; k < N; k++) chk("post_reset_phase", nth_of(k, 0), 0);
        chk("post_reset_outputs", seen_ch.size(), 4);

`ifdef PHASE_SLOT_HARD_SYNC_EN
        do_reset();
        clear_seen();
        step(0, 1, 0, 32'h8000_0000, 0);
        step(0, 1, 1, 32'h1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0);
            idle(5);
        end
        chk("sync_sweep0", nth_of(1, 0), 32'h1);
        chk("sync_sweep1", nth_of(1, 1), 32'h1);
        chk("sync_sweep2", nth_of(1, 2), 32'h2);
        chk("sync_sweep3", nth_of(1, 3), 32'h1);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [PW-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? (32'hF000_0000 | PW'($urandom_range(0, 255)))
                                            : PW'($urandom);
            step($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                 CB'($urandom_range(0, N - 1)), d, $urandom_range(0, 3) == 0);
        end
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
